// File: rtl/conv3x3_mac_engine.sv
// 2x2 valid cross-correlation of a 4x4 data tile with a 3x3 filter, computed
// with one shared multiplier-accumulator (one MAC per cycle, 36 MACs per run).
module conv3x3_mac_engine #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] a11,
  input  logic [DATA_W-1:0] a12,
  input  logic [DATA_W-1:0] a13,
  input  logic [DATA_W-1:0] a14,
  input  logic [DATA_W-1:0] a21,
  input  logic [DATA_W-1:0] a22,
  input  logic [DATA_W-1:0] a23,
  input  logic [DATA_W-1:0] a24,
  input  logic [DATA_W-1:0] a31,
  input  logic [DATA_W-1:0] a32,
  input  logic [DATA_W-1:0] a33,
  input  logic [DATA_W-1:0] a34,
  input  logic [DATA_W-1:0] a41,
  input  logic [DATA_W-1:0] a42,
  input  logic [DATA_W-1:0] a43,
  input  logic [DATA_W-1:0] a44,
  input  logic [DATA_W-1:0] b11,
  input  logic [DATA_W-1:0] b12,
  input  logic [DATA_W-1:0] b13,
  input  logic [DATA_W-1:0] b21,
  input  logic [DATA_W-1:0] b22,
  input  logic [DATA_W-1:0] b23,
  input  logic [DATA_W-1:0] b31,
  input  logic [DATA_W-1:0] b32,
  input  logic [DATA_W-1:0] b33,
  output logic              busy,
  output logic              done,
  output logic [ACC_W-1:0]  c11,
  output logic [ACC_W-1:0]  c12,
  output logic [ACC_W-1:0]  c21,
  output logic [ACC_W-1:0]  c22
);

  typedef enum logic {IDLE, CALC} state_t;

  state_t            state;
  logic [DATA_W-1:0] a_in [16];
  logic [DATA_W-1:0] b_in [9];
  logic [DATA_W-1:0] a_q  [16];
  logic [DATA_W-1:0] b_q  [9];
  logic [ACC_W-1:0]  res  [4];
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_next;
  logic [1:0]        out_idx;
  logic [3:0]        tap;
  logic [1:0]        tap_i;
  logic [1:0]        tap_j;
  logic [1:0]        row;
  logic [1:0]        col;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [2*DATA_W-1:0] prod;

  // Row-major flattening: data index = row*4 + col, filter index = row*3 + col.
  always_comb begin
    a_in[0]  = a11; a_in[1]  = a12; a_in[2]  = a13; a_in[3]  = a14;
    a_in[4]  = a21; a_in[5]  = a22; a_in[6]  = a23; a_in[7]  = a24;
    a_in[8]  = a31; a_in[9]  = a32; a_in[10] = a33; a_in[11] = a34;
    a_in[12] = a41; a_in[13] = a42; a_in[14] = a43; a_in[15] = a44;
    b_in[0]  = b11; b_in[1]  = b12; b_in[2]  = b13;
    b_in[3]  = b21; b_in[4]  = b22; b_in[5]  = b23;
    b_in[6]  = b31; b_in[7]  = b32; b_in[8]  = b33;
  end

  // NOTE: every signal driven here gets a default first, so no latch is inferred.
  always_comb begin
    tap_i = 2'd0;
    tap_j = 2'd0;
    case (tap)
      4'd1:    begin tap_i = 2'd0; tap_j = 2'd1; end
      4'd2:    begin tap_i = 2'd0; tap_j = 2'd2; end
      4'd3:    begin tap_i = 2'd1; tap_j = 2'd0; end
      4'd4:    begin tap_i = 2'd1; tap_j = 2'd1; end
      4'd5:    begin tap_i = 2'd1; tap_j = 2'd2; end
      4'd6:    begin tap_i = 2'd2; tap_j = 2'd0; end
      4'd7:    begin tap_i = 2'd2; tap_j = 2'd1; end
      4'd8:    begin tap_i = 2'd2; tap_j = 2'd2; end
      default: begin tap_i = 2'd0; tap_j = 2'd0; end
    endcase
  end

  // out_idx bit 1 selects the output row, bit 0 the output column.
  always_comb begin
    row      = {1'b0, out_idx[1]} + tap_i;
    col      = {1'b0, out_idx[0]} + tap_j;
    op_a     = a_q[{row, col}];
    op_b     = b_q[tap];
    prod     = op_a * op_b;
    acc_next = acc + ACC_W'(prod);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      c11     <= '0;
      c12     <= '0;
      c21     <= '0;
      c22     <= '0;
      acc     <= '0;
      out_idx <= '0;
      tap     <= '0;
      // NOTE: the operand and result copies are small register files, so they
      // are cleared on reset like any other state; no RAM macro is implied.
      for (int k = 0; k < 16; k++) a_q[k] <= '0;
      for (int k = 0; k < 9; k++)  b_q[k] <= '0;
      for (int k = 0; k < 4; k++)  res[k] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q     <= a_in;
            b_q     <= b_in;
            acc     <= '0;
            out_idx <= '0;
            tap     <= '0;
            busy    <= 1'b1;
            state   <= CALC;
          end
        end
        CALC: begin
          if (tap == 4'd8) begin
            res[out_idx] <= acc_next;
            acc          <= '0;
            tap          <= '0;
            out_idx      <= out_idx + 2'd1;
            if (out_idx == 2'd3) begin
              // The last result bypasses res so all four outputs update together.
              c11   <= res[0];
              c12   <= res[1];
              c21   <= res[2];
              c22   <= acc_next;
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else begin
            acc <= acc_next;
            tap <= tap + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv3x3_mac_engine.sv
// Directed bench for conv3x3_mac_engine: table of operand sets with
// hand-computed results, plus sequences for abort, back-to-back and ignored start.
module tb_conv3x3_mac_engine;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 20;

  typedef struct packed {
    logic [15:0][DATA_W-1:0] a;
    logic [8:0][DATA_W-1:0]  b;
    logic [3:0][ACC_W-1:0]   c;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic [15:0][DATA_W-1:0] a_drv = '0;
  logic [8:0][DATA_W-1:0]  b_drv = '0;
  logic busy, done;
  logic [ACC_W-1:0] c11, c12, c21, c22;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vecs [5];

  always #5 clk = ~clk;

  conv3x3_mac_engine #(.DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .a11(a_drv[0]),  .a12(a_drv[1]),  .a13(a_drv[2]),  .a14(a_drv[3]),
    .a21(a_drv[4]),  .a22(a_drv[5]),  .a23(a_drv[6]),  .a24(a_drv[7]),
    .a31(a_drv[8]),  .a32(a_drv[9]),  .a33(a_drv[10]), .a34(a_drv[11]),
    .a41(a_drv[12]), .a42(a_drv[13]), .a43(a_drv[14]), .a44(a_drv[15]),
    .b11(b_drv[0]), .b12(b_drv[1]), .b13(b_drv[2]),
    .b21(b_drv[3]), .b22(b_drv[4]), .b23(b_drv[5]),
    .b31(b_drv[6]), .b32(b_drv[7]), .b33(b_drv[8]),
    .busy(busy), .done(done),
    .c11(c11), .c12(c12), .c21(c21), .c22(c22)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Advance one rising edge; outputs are then sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_c(input string name, input logic [3:0][ACC_W-1:0] exp);
    check({name, " c11"}, 32'(c11), 32'(exp[0]));
    check({name, " c12"}, 32'(c12), 32'(exp[1]));
    check({name, " c21"}, 32'(c21), 32'(exp[2]));
    check({name, " c22"}, 32'(c22), 32'(exp[3]));
  endtask

  // Pulse start (sampled at E0), wait for done with a bound, check latency,
  // busy duration, results and done pulse width.
  task automatic run_vec(input string name, input vec_t v);
    int lat;
    int busy_cnt;
    a_drv = v.a;
    b_drv = v.b;
    start = 1'b1;
    tick();
    start = 1'b0;
    busy_cnt = busy ? 1 : 0;
    lat = 0;
    for (int n = 1; n <= 100; n++) begin
      tick();
      if (done) begin
        lat = n;
        break;
      end
      if (busy) busy_cnt++;
    end
    check({name, " latency"}, 32'(lat), 32'd36);
    check({name, " busy cycles"}, 32'(busy_cnt), 32'd36);
    check({name, " busy in done cycle"}, 32'(busy), 32'd0);
    check_c(name, v.c);
    tick();
    check({name, " done width"}, 32'(done), 32'd0);
  endtask

  function automatic logic [15:0][DATA_W-1:0] ramp16();
    logic [15:0][DATA_W-1:0] r;
    for (int k = 0; k < 16; k++) r[k] = DATA_W'(k + 1);
    return r;
  endfunction

  function automatic logic [15:0][DATA_W-1:0] fill16(input logic [DATA_W-1:0] x);
    logic [15:0][DATA_W-1:0] r;
    for (int k = 0; k < 16; k++) r[k] = x;
    return r;
  endfunction

  function automatic logic [8:0][DATA_W-1:0] fill9(input logic [DATA_W-1:0] x);
    logic [8:0][DATA_W-1:0] r;
    for (int k = 0; k < 9; k++) r[k] = x;
    return r;
  endfunction

  initial begin
    int ndone;
    int first_done;
    int gap;
    logic [8:0][DATA_W-1:0] bt;

    // Table: all ones; ramp with centre tap; saturated; ramp with box filter;
    // ramp with asymmetric filter b = 1..9 (catches transposed indexing).
    vecs[0].a = fill16(8'd1);
    vecs[0].b = fill9(8'd1);
    vecs[0].c = {20'd9, 20'd9, 20'd9, 20'd9};
    vecs[1].a = ramp16();
    vecs[1].b = '0;
    vecs[1].b[4] = 8'd1;
    vecs[1].c = {20'd11, 20'd10, 20'd7, 20'd6};
    vecs[2].a = fill16(8'd255);
    vecs[2].b = fill9(8'd255);
    vecs[2].c = {20'h8EE09, 20'h8EE09, 20'h8EE09, 20'h8EE09};
    vecs[3].a = ramp16();
    vecs[3].b = fill9(8'd1);
    vecs[3].c = {20'd99, 20'd90, 20'd63, 20'd54};
    for (int k = 0; k < 9; k++) bt[k] = DATA_W'(k + 1);
    vecs[4].a = ramp16();
    vecs[4].b = bt;
    vecs[4].c = {20'd573, 20'd528, 20'd393, 20'd348};

    rst = 1'b0;
    tick();
    tick();
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check_c("reset", '0);
    rst = 1'b1;
    tick();

    for (int t = 0; t < 5; t++) begin
      run_vec($sformatf("vec%0d", t), vecs[t]);
      tick();
    end

    // Inputs zeroed at E5 and a start pulse at E10 must not disturb the run.
    a_drv = vecs[3].a;
    b_drv = vecs[3].b;
    start = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0;
    first_done = 0;
    for (int n = 1; n <= 80; n++) begin
      if (n == 5) begin
        a_drv = '0;
        b_drv = '0;
      end
      start = (n == 10);
      tick();
      if (done) begin
        ndone++;
        if (first_done == 0) first_done = n;
      end
    end
    start = 1'b0;
    check("ignored start done count", 32'(ndone), 32'd1);
    check("ignored start latency", 32'(first_done), 32'd36);
    check("ignored start busy after", 32'(busy), 32'd0);
    check_c("frozen operands", vecs[3].c);

    // Back-to-back: start asserted in the done cycle is taken at E37.
    a_drv = vecs[3].a;
    b_drv = vecs[3].b;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n <= 100 && !done; n++) tick();
    check("b2b first done", 32'(done), 32'd1);
    check_c("b2b first", vecs[3].c);
    a_drv = vecs[4].a;
    b_drv = vecs[4].b;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("b2b busy after E37", 32'(busy), 32'd1);
    gap = 0;
    for (int n = 2; n <= 100; n++) begin
      tick();
      if (n == 20) check("b2b c11 held", 32'(c11), 32'd54);
      if (done) begin
        gap = n;
        break;
      end
    end
    check("b2b done spacing", 32'(gap), 32'd37);
    check_c("b2b second", vecs[4].c);
    tick();

    // Reset at E20 aborts the run: outputs clear and no done appears.
    a_drv = vecs[0].a;
    b_drv = vecs[0].b;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n < 20; n++) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("abort busy", 32'(busy), 32'd0);
    check_c("abort", '0);
    ndone = 0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (done) ndone++;
    end
    check("abort no done", 32'(ndone), 32'd0);
    check("abort c22 stays 0", 32'(c22), 32'd0);
    run_vec("after abort", vecs[1]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/conv3x3_mac_engine.md
Name: conv3x3_mac_engine

Overview:
- Compute stage directly downstream of the operand memory that holds the 4x4 data tile (a11..a44) and the 3x3 filter (b11..b33).
- Started by that memory's activate_done pulse; computes the 2x2 valid convolution (no filter flip, cross-correlation form) using one shared 8x8 multiplier-accumulator, one MAC per cycle.
- Presents the four results together, with a one-cycle done pulse, to the next stage.

Parameters:
- DATA_W, 8: width of every data and filter operand; unsigned.
- ACC_W, 20: accumulator and result width; must be >= 2*DATA_W+4. The default holds 9*255*255 = 585225 without overflow.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-low reset (0 = reset, sampled on the clk rising edge)
- start  input  1  one-cycle request; driven by the memory's activate_done
- a11..a14, a21..a24, a31..a34, a41..a44  input  DATA_W each  data tile, row/column indexed
- b11..b13, b21..b23, b31..b33  input  DATA_W each  filter taps
- busy  output  1  high while a computation is in progress
- done  output  1  one-cycle pulse; results valid and updated in this cycle
- c11, c12, c21, c22  output  ACC_W each  convolution results, row/column indexed

Behaviour:
- Reset, when rst=0 at a clk edge:
  - state goes to IDLE;
  - busy=0, done=0, c11=c12=c21=c22=0;
  - all counters, the accumulator and the operand copies are cleared.
  - Reset applied mid-computation aborts it: no done pulse, and the outputs become 0.
- FSM states: IDLE and CALC.
- IDLE:
  - Edge with start=1 (call it E0): capture all 25 operands into internal registers, clear the accumulator, set out_idx=0 and tap=0, go to CALC.
  - Later changes on the a*/b* inputs do not affect the computation in flight.
- CALC, at each edge E1..E36:
  - Output position (r,s): out_idx 0..3 maps to (0,0), (0,1), (1,0), (1,1).
  - Tap (i,j): i = tap/3, j = tap%3.
  - Operation: acc <= acc + A[r+i][s+j]*B[i][j]. All arithmetic is unsigned, with zero-extension to ACC_W.
  - When tap=8: write acc+product into internal result register out_idx, clear acc, set tap=0, increment out_idx. Otherwise increment tap.
  - When tap=8 and out_idx=3 (edge E36): load c11, c12, c21, c22 from the internal results all together, set done=1, go to IDLE.
- Output timing and latency:
  - c outputs change only at the completion edge; they hold their values between computations.
  - done is registered; it is high from E36 to E37 only.
  - Latency: done rises exactly 36 clock edges after the edge that sampled start.
- busy: registered; 1 from E0 up to E36, 0 in the done cycle.
- start while in CALC: ignored; no queuing, no restart.
- start=1 in the done cycle: accepted at E37, because the FSM is already in IDLE. This gives back-to-back operation with throughput of one result set per 37 cycles.
- start held high continuously: a new computation begins every 37 cycles.
- No overflow is possible at the defaults. With non-default parameters the result wraps modulo 2^ACC_W.

Test Plan:
- Reset, then all a=1 and all b=1, pulse start: done rises 36 edges after start is sampled; c11=c12=c21=c22=9; busy high for 36 cycles.
- a = 1..16 row-major (a11=1 ... a44=16); b22=1, other taps 0 -> c11=6, c12=7, c21=10, c22=11.
- All operands 255 -> every c = 585225 (0x8EE09); no wrap.
- a = 1..16 with all b=1 -> c11=54, c12=63, c21=90, c22=99. Change every input to 0 at E5 and pulse start at E10: results unchanged, a single done pulse at E36.
- After the first result set, reprogram the inputs and assert start in the done cycle -> second done pulse exactly 37 edges after the first. c keeps its old values until that second done.
- Pull rst low at E20 for one edge -> busy=0, all c=0, no done pulse. A fresh start afterwards completes normally with correct results.
